// File: rtl/led_pwm_multi.sv
// Multi-channel LED driver: one shared period counter, per-channel on-window, mode and N-blink.
// Optional macro LED_SHADOW_EN defers window/period writes to the next period wrap.
module led_pwm_multi #(
  parameter int unsigned CH_NUM    = 4,
  parameter int unsigned CH_W      = 2,
  parameter int unsigned CNT_W     = 23,
  parameter int unsigned PERIOD    = 5_000_000,
  parameter int unsigned RST_START = 3_750_000,
  parameter int unsigned RST_END   = 5_000_000,
  parameter logic [1:0]  RST_MODE  = 2'b10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Cfg_Wr,
  input  logic [CH_W-1:0]   Cfg_Ch,
  input  logic [1:0]        Cfg_Field,
  input  logic [CNT_W-1:0]  Cfg_Data,
  output logic [CH_NUM-1:0] LED_Out,
  output logic [CH_NUM-1:0] Done,
  output logic              Period_Tick
);

  typedef enum logic [1:0] {ModeOff, ModeOn, ModeWin, ModeBlink} mode_e;
  localparam int unsigned BlinkW = 8;

  logic [CNT_W-1:0]  count_q, count_d, term_q, term_d;
  logic [CNT_W-1:0]  start_q [CH_NUM];
  logic [CNT_W-1:0]  start_d [CH_NUM];
  logic [CNT_W-1:0]  end_q   [CH_NUM];
  logic [CNT_W-1:0]  end_d   [CH_NUM];
  mode_e             mode_q  [CH_NUM];
  mode_e             mode_d  [CH_NUM];
  logic [BlinkW-1:0] rem_q   [CH_NUM];
  logic [BlinkW-1:0] rem_d   [CH_NUM];
  logic [CH_NUM-1:0] led_q, led_d, done_q, done_d, hit, ch_sel;
  logic              tick_q;
  logic              wrap, wr_start, wr_end, wr_mode, wr_term;
  mode_e             wr_mode_val;
  logic [BlinkW-1:0] wr_blinks;

`ifdef LED_SHADOW_EN
  logic [CNT_W-1:0]  term_sh_q, term_sh_d;
  logic              term_pend_q, term_pend_d;
  logic [CNT_W-1:0]  start_sh_q [CH_NUM];
  logic [CNT_W-1:0]  start_sh_d [CH_NUM];
  logic [CNT_W-1:0]  end_sh_q   [CH_NUM];
  logic [CNT_W-1:0]  end_sh_d   [CH_NUM];
  logic [CH_NUM-1:0] start_pend_q, start_pend_d, end_pend_q, end_pend_d;
`endif

  assign wrap        = (count_q >= term_q);
  assign count_d     = wrap ? '0 : count_q + CNT_W'(1);
  assign wr_start    = Cfg_Wr && (Cfg_Field == 2'd0);
  assign wr_end      = Cfg_Wr && (Cfg_Field == 2'd1);
  assign wr_mode     = Cfg_Wr && (Cfg_Field == 2'd2);
  assign wr_term     = Cfg_Wr && (Cfg_Field == 2'd3);
  assign wr_mode_val = mode_e'(Cfg_Data[1:0]);
  assign wr_blinks   = Cfg_Data[9:2];

  // Out-of-range channel numbers match no channel, so those writes are dropped.
  always_comb begin
    for (int i = 0; i < int'(CH_NUM); i++) begin
      ch_sel[i] = (int'(Cfg_Ch) == i);
    end
  end

  always_comb begin
    for (int i = 0; i < int'(CH_NUM); i++) begin
      if (start_q[i] <= end_q[i]) begin
        hit[i] = (count_q >= start_q[i]) && (count_q <= end_q[i]);
      end else begin
        hit[i] = (count_q >= start_q[i]) || (count_q <= end_q[i]);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(CH_NUM); i++) begin
      mode_d[i] = mode_q[i];
      rem_d[i]  = rem_q[i];
      done_d[i] = 1'b0;
      led_d[i]  = 1'b0;
      unique case (mode_q[i])
        ModeOff:   led_d[i] = 1'b0;
        ModeOn:    led_d[i] = 1'b1;
        ModeWin:   led_d[i] = hit[i];
        ModeBlink: led_d[i] = hit[i] && (rem_q[i] != '0);
      endcase
      // A mode write beats a same-cycle wrap decrement.
      if (wr_mode && ch_sel[i]) begin
        mode_d[i] = wr_mode_val;
        if (wr_mode_val == ModeBlink) begin
          rem_d[i]  = wr_blinks;
          done_d[i] = (wr_blinks == '0);
        end else begin
          rem_d[i] = '0;
        end
      end else if ((mode_q[i] == ModeBlink) && wrap && (rem_q[i] != '0)) begin
        rem_d[i]  = rem_q[i] - BlinkW'(1);
        done_d[i] = (rem_q[i] == BlinkW'(1));
      end
    end
  end

  always_comb begin
    term_d = term_q;
`ifdef LED_SHADOW_EN
    term_sh_d   = term_sh_q;
    term_pend_d = term_pend_q;
    if (wrap && term_pend_q) begin
      term_d      = term_sh_q;
      term_pend_d = 1'b0;
    end
    if (wr_term) begin
      term_sh_d   = Cfg_Data;
      term_pend_d = 1'b1;
    end
`else
    if (wr_term) term_d = Cfg_Data;
`endif
    for (int i = 0; i < int'(CH_NUM); i++) begin
      start_d[i] = start_q[i];
      end_d[i]   = end_q[i];
`ifdef LED_SHADOW_EN
      start_sh_d[i]   = start_sh_q[i];
      end_sh_d[i]     = end_sh_q[i];
      start_pend_d[i] = start_pend_q[i];
      end_pend_d[i]   = end_pend_q[i];
      if (wrap && start_pend_q[i]) begin
        start_d[i]      = start_sh_q[i];
        start_pend_d[i] = 1'b0;
      end
      if (wrap && end_pend_q[i]) begin
        end_d[i]      = end_sh_q[i];
        end_pend_d[i] = 1'b0;
      end
      // A write landing on the wrap cycle stays pending until the following wrap.
      if (wr_start && ch_sel[i]) begin
        start_sh_d[i]   = Cfg_Data;
        start_pend_d[i] = 1'b1;
      end
      if (wr_end && ch_sel[i]) begin
        end_sh_d[i]   = Cfg_Data;
        end_pend_d[i] = 1'b1;
      end
`else
      if (wr_start && ch_sel[i]) start_d[i] = Cfg_Data;
      if (wr_end && ch_sel[i])   end_d[i]   = Cfg_Data;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
      term_q  <= CNT_W'(PERIOD);
      led_q   <= '0;
      done_q  <= '0;
      tick_q  <= 1'b0;
      for (int i = 0; i < int'(CH_NUM); i++) begin
        start_q[i] <= CNT_W'(RST_START);
        end_q[i]   <= CNT_W'(RST_END);
        mode_q[i]  <= mode_e'(RST_MODE);
        rem_q[i]   <= '0;
      end
`ifdef LED_SHADOW_EN
      term_sh_q    <= CNT_W'(PERIOD);
      term_pend_q  <= 1'b0;
      start_pend_q <= '0;
      end_pend_q   <= '0;
      for (int i = 0; i < int'(CH_NUM); i++) begin
        start_sh_q[i] <= CNT_W'(RST_START);
        end_sh_q[i]   <= CNT_W'(RST_END);
      end
`endif
    end else begin
      count_q <= count_d;
      term_q  <= term_d;
      led_q   <= led_d;
      done_q  <= done_d;
      tick_q  <= wrap;
      for (int i = 0; i < int'(CH_NUM); i++) begin
        start_q[i] <= start_d[i];
        end_q[i]   <= end_d[i];
        mode_q[i]  <= mode_d[i];
        rem_q[i]   <= rem_d[i];
      end
`ifdef LED_SHADOW_EN
      term_sh_q    <= term_sh_d;
      term_pend_q  <= term_pend_d;
      start_pend_q <= start_pend_d;
      end_pend_q   <= end_pend_d;
      for (int i = 0; i < int'(CH_NUM); i++) begin
        start_sh_q[i] <= start_sh_d[i];
        end_sh_q[i]   <= end_sh_d[i];
      end
`endif
    end
  end

  assign LED_Out     = led_q;
  assign Done        = done_q;
  assign Period_Tick = tick_q;

endmodule
